mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Pipeline MEM stage; consumer of the execute-stage outputs (instruction, type, result, store data, branch flag).
- Performs loads/stores against a variable-latency data memory over a req/ack handshake, stalling upstream while a memory access is outstanding.
- Passes ALU results and branch resolution through to the writeback stage as registered, single-cycle-valid outputs.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles in BUSY without Mem_Ack_In before aborting (must be ≥ 1).
- CNT_W, 5, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT_CYCLES).

Ports:
- Clk_In  input  1  clock; all state updates on rising edge.
- Reset_In  input  1  reset (see interface line under Behaviour).
- Valid_In  input  1  execute-stage outputs valid this cycle.
- Inst_In  input  32  instruction; rd = Inst_In[11:7].
- Inst_Type_In  input  5  opcode[6:2] class.
- Result_In  input  32  ALU result, effective address, or branch target.
- Operand_B_In  input  32  store data.
- isBranchTaken_In  input  1  branch resolved taken.
- Stall_Out  output  1  upstream must hold; Valid_In is ignored while high.
- Mem_Req_Out  output  1  memory request.
- Mem_We_Out  output  1  1 = store, 0 = load.
- Mem_Addr_Out  output  32  access address.
- Mem_WData_Out  output  32  store data.
- Mem_Ack_In  input  1  memory completion.
- Mem_RData_In  input  32  load data; valid when Mem_Ack_In = 1.
- WB_Valid_Out  output  1  one-cycle pulse per retired instruction.
- WB_Inst_Out  output  32  retired instruction.
- WB_Inst_Type_Out  output  5  retired type.
- WB_Data_Out  output  32  writeback value.
- WB_Rd_Out  output  5  destination register.
- WB_RegWrite_Out  output  1  register-file write enable.
- Branch_Taken_Out  output  1  one-cycle pulse when a taken branch retires.
- Branch_Target_Out  output  32  target address; valid with Branch_Taken_Out.
- Mem_Error_Out  output  1  one-cycle pulse on timeout.

Behaviour:
- Interface: one clock, Clk_In; Reset_In is synchronous, active-high.
- Type codes: IMM = 00100, RR = 01100, LOAD = 00000, STORE = 01000, BRANCH = 11000, MAC = 11111.
- Reset: FSM returns to IDLE; counter cleared; every output is 0.
  - Reset during BUSY drops Mem_Req_Out at that edge.
  - No WB or error pulse is generated for the aborted access.
- FSM has two states, IDLE and BUSY.
- Stall_Out = (state == BUSY). This is a Moore output with no combinational path from inputs.
- IDLE, Valid_In = 1, type LOAD or STORE:
  - latch instruction, type, address = Result_In, wdata = Operand_B_In, we = (type == STORE);
  - go to BUSY and clear the counter.
  - Mem_Req_Out rises on the same edge, so the request is seen one cycle after acceptance.
- IDLE, Valid_In = 1, other types: retire next cycle (1-cycle latency).
  - WB_Valid_Out = 1.
  - WB_Data_Out = Result_In.
  - WB_RegWrite_Out = 1 for IMM or RR, 0 otherwise.
  - BRANCH with isBranchTaken_In = 1: Branch_Taken_Out = 1 and Branch_Target_Out = Result_In.
  - MAC and unknown types retire with RegWrite = 0.
- BUSY:
  - Mem_Req_Out, Mem_We_Out, Mem_Addr_Out and Mem_WData_Out are held stable until the ack.
  - The counter increments each cycle.
  - On Mem_Ack_In = 1: deassert request at that edge; WB_Valid_Out pulses the next cycle; return to IDLE.
    - LOAD: WB_Data_Out = Mem_RData_In captured at the ack edge, RegWrite = 1.
    - STORE: WB_Data_Out = 0, RegWrite = 0.
  - The counter reaches TIMEOUT_CYCLES without an ack: Mem_Error_Out and WB_Valid_Out pulse together with RegWrite = 0; return to IDLE.
  - Ack arriving in the same cycle the timeout is reached: ack wins and there is no error.
- Mem_Ack_In while in IDLE is ignored.
- rd = 0 forces WB_RegWrite_Out = 0 for all types.
- WB_Valid_Out, Branch_Taken_Out and Mem_Error_Out are zero in every cycle where nothing retires.
- WB_* data fields may hold stale values when WB_Valid_Out = 0.
- Back-to-back non-memory instructions sustain 1 per cycle. A memory access blocks acceptance until return to IDLE; the next instruction is accepted in the cycle the WB pulse appears.

Decomposition:
- Shared package pipeline_pkg: inst-type codes (shared with execute/decode) and FSM state encoding.
- One sub-module mem_timeout_counter (CNT_W counter with clear/enable/expired); everything else stays inline.

Test Plan:
- RR ADD with rd = 5, Result_In = 0x0000_0010, Valid_In for 1 cycle -> next cycle WB_Valid_Out = 1, WB_Data_Out = 0x10, WB_Rd_Out = 5, WB_RegWrite_Out = 1, Stall_Out stays 0.
- LOAD with addr 0x100, memory acks 3 cycles after request with RData 0xDEAD_BEEF -> Mem_Req_Out held for 3 cycles with addr 0x100 and We = 0, Stall_Out = 1 throughout; WB_Data_Out = 0xDEAD_BEEF, RegWrite = 1 the cycle after ack.
- STORE with addr 0x200, Operand_B_In = 0x1234, ack on first request cycle -> Mem_We_Out = 1, Mem_WData_Out = 0x1234; WB_Valid_Out pulses with RegWrite = 0, 2 cycles after accept.
- BRANCH with taken = 1, Result_In = 0x40 -> Branch_Taken_Out pulses with target 0x40, RegWrite = 0; taken = 0 -> no pulse, WB_Valid_Out = 1.
- LOAD with no ack, TIMEOUT_CYCLES = 16 -> Mem_Error_Out and WB_Valid_Out pulse together after 16 BUSY cycles, request drops, FSM returns to IDLE; repeat with ack on cycle 16 -> no error and load data is written back.
- Reset_In asserted during BUSY -> all outputs 0 the next cycle, no WB pulse; a later ack in IDLE is ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction-class codes (opcode[6:2]) used by
// decode/execute/mem, plus the memory-stage FSM state encoding.
package pipeline_pkg;

    localparam logic [4:0] TYPE_LOAD   = 5'b00000;
    localparam logic [4:0] TYPE_IMM    = 5'b00100;
    localparam logic [4:0] TYPE_STORE  = 5'b01000;
    localparam logic [4:0] TYPE_RR     = 5'b01100;
    localparam logic [4:0] TYPE_BRANCH = 5'b11000;
    localparam logic [4:0] TYPE_MAC    = 5'b11111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    function automatic logic is_mem_type(input logic [4:0] inst_type);
        return (inst_type == TYPE_LOAD) || (inst_type == TYPE_STORE);
    endfunction

    function automatic logic is_alu_type(input logic [4:0] inst_type);
        return (inst_type == TYPE_IMM) || (inst_type == TYPE_RR);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on the data memory; expired is asserted during
// the last allowed wait cycle so the FSM can abort at the following edge.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Reaching TIMEOUT_CYCLES at the next edge means this is the final wait cycle.
    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: retires ALU/branch results in one cycle and performs
// loads/stores over a req/ack handshake with a timeout, stalling upstream.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        Clk_In,
    input  logic        Reset_In,
    input  logic        Valid_In,
    input  logic [31:0] Inst_In,
    input  logic [4:0]  Inst_Type_In,
    input  logic [31:0] Result_In,
    input  logic [31:0] Operand_B_In,
    input  logic        isBranchTaken_In,
    output logic        Stall_Out,
    output logic        Mem_Req_Out,
    output logic        Mem_We_Out,
    output logic [31:0] Mem_Addr_Out,
    output logic [31:0] Mem_WData_Out,
    input  logic        Mem_Ack_In,
    input  logic [31:0] Mem_RData_In,
    output logic        WB_Valid_Out,
    output logic [31:0] WB_Inst_Out,
    output logic [4:0]  WB_Inst_Type_Out,
    output logic [31:0] WB_Data_Out,
    output logic [4:0]  WB_Rd_Out,
    output logic        WB_RegWrite_Out,
    output logic        Branch_Taken_Out,
    output logic [31:0] Branch_Target_Out,
    output logic        Mem_Error_Out
);

    mem_state_e  state;
    logic [31:0] mem_inst;
    logic [4:0]  mem_type;
    logic        expired;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timeout (
        .clk    (Clk_In),
        .rst    (Reset_In),
        .clear  (state != ST_BUSY),
        .enable (state == ST_BUSY),
        .expired(expired)
    );

    assign Stall_Out = (state == ST_BUSY);

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state             <= ST_IDLE;
            mem_inst          <= '0;
            mem_type          <= '0;
            Mem_Req_Out       <= 1'b0;
            Mem_We_Out        <= 1'b0;
            Mem_Addr_Out      <= '0;
            Mem_WData_Out     <= '0;
            WB_Valid_Out      <= 1'b0;
            WB_Inst_Out       <= '0;
            WB_Inst_Type_Out  <= '0;
            WB_Data_Out       <= '0;
            WB_Rd_Out         <= '0;
            WB_RegWrite_Out   <= 1'b0;
            Branch_Taken_Out  <= 1'b0;
            Branch_Target_Out <= '0;
            Mem_Error_Out     <= 1'b0;
        end else begin
            WB_Valid_Out     <= 1'b0;
            Branch_Taken_Out <= 1'b0;
            Mem_Error_Out    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Valid_In && is_mem_type(Inst_Type_In)) begin
                        mem_inst      <= Inst_In;
                        mem_type      <= Inst_Type_In;
                        Mem_Req_Out   <= 1'b1;
                        Mem_We_Out    <= (Inst_Type_In == TYPE_STORE);
                        Mem_Addr_Out  <= Result_In;
                        Mem_WData_Out <= Operand_B_In;
                        state         <= ST_BUSY;
                    end else if (Valid_In) begin
                        WB_Valid_Out     <= 1'b1;
                        WB_Inst_Out      <= Inst_In;
                        WB_Inst_Type_Out <= Inst_Type_In;
                        WB_Data_Out      <= Result_In;
                        WB_Rd_Out        <= Inst_In[11:7];
                        WB_RegWrite_Out  <= is_alu_type(Inst_Type_In) && (Inst_In[11:7] != 5'd0);
                        if ((Inst_Type_In == TYPE_BRANCH) && isBranchTaken_In) begin
                            Branch_Taken_Out  <= 1'b1;
                            Branch_Target_Out <= Result_In;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (Mem_Ack_In || expired) begin
                        Mem_Req_Out      <= 1'b0;
                        WB_Valid_Out     <= 1'b1;
                        WB_Inst_Out      <= mem_inst;
                        WB_Inst_Type_Out <= mem_type;
                        WB_Rd_Out        <= mem_inst[11:7];
                        state            <= ST_IDLE;
                        if (!Mem_Ack_In) begin
                            Mem_Error_Out   <= 1'b1;
                            WB_Data_Out     <= '0;
                            WB_RegWrite_Out <= 1'b0;
                        end else if (Mem_We_Out) begin
                            WB_Data_Out     <= '0;
                            WB_RegWrite_Out <= 1'b0;
                        end else begin
                            WB_Data_Out     <= Mem_RData_In;
                            WB_RegWrite_Out <= (mem_inst[11:7] != 5'd0);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
